// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer: register map, TCR/TSR bit positions
// and the APB slave phase encoding.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int unsigned TCR_LOAD   = 7;
    localparam int unsigned TCR_DN     = 5;
    localparam int unsigned TCR_EN     = 4;
    localparam int unsigned TCR_CKS_HI = 1;
    localparam int unsigned TCR_CKS_LO = 0;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

    // Implemented TCR bits; bits 6,3,2 are reserved and never stored.
    localparam logic [7:0] TCR_RW_MASK = 8'hB3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

    function automatic logic [7:0] tcr_filter(input logic [7:0] wdata);
        return wdata & TCR_RW_MASK;
    endfunction

endpackage

// File: rtl/timer_apb_regif_apb_slv_fsm.sv
// APB slave handshake: tracks SETUP/ACCESS phases, inserts WAIT_STATES wait
// cycles and flags the single completion cycle as a write or read strobe.
module apb_slv_fsm
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic pclk,
    input  logic presetn,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    output logic pready,
    output logic wr_stb,
    output logic rd_stb
);

    apb_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] cnt_cur;
    logic       in_access;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // SETUP state means the setup cycle was seen; the first access cycle is count 0.
    assign cnt_cur   = (state_q == ST_SETUP) ? '0 : cnt_q;
    assign in_access = (state_q != ST_IDLE) && psel && penable;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pready  = in_access && (cnt_cur == 3'(WAIT_STATES));
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!psel || pready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    state_d = ST_ACCESS;
                    cnt_d   = cnt_cur + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign wr_stb = pready && pwrite;
    assign rd_stb = pready && !pwrite;

endmodule

// File: rtl/timer_apb_regif.sv
// Timer register file behind an APB slave: TDR/TCR control, sticky TSR
// flags fed by the counter core, read-only TCNT view.
module timer_apb_regif
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        tdr_o,
    output logic              load_o,
    output logic              dn_o,
    output logic              en_o,
    output logic [1:0]        cks_o,
    input  logic [7:0]        tcnt_i,
    input  logic              ovf_set_i,
    input  logic              udf_set_i
);

    logic       wr_stb, rd_stb;
    logic       hit_tdr, hit_tcr, hit_tsr, hit_tcnt, err;
    logic       wr_ok;
    logic [7:0] tdr_q, tcr_q, prdata_q, rdata, rd_value;
    logic [1:0] tsr_q, tsr_d, tsr_clr;

    apb_slv_fsm #(
        .WAIT_STATES(WAIT_STATES)
    ) u_fsm (
        .pclk   (pclk),
        .presetn(presetn),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .pready (pready),
        .wr_stb (wr_stb),
        .rd_stb (rd_stb)
    );

    assign hit_tdr  = (paddr == ADDR_W'(ADDR_TDR));
    assign hit_tcr  = (paddr == ADDR_W'(ADDR_TCR));
    assign hit_tsr  = (paddr == ADDR_W'(ADDR_TSR));
    assign hit_tcnt = (paddr == ADDR_W'(ADDR_TCNT));
    assign err      = !(hit_tdr || hit_tcr || hit_tsr || hit_tcnt) || (pwrite && hit_tcnt);
    assign wr_ok    = wr_stb && !err;
    assign pslverr  = pready && err;

    // Write-0-to-clear; a same-cycle set from the counter core overrides the clear.
    assign tsr_clr = (wr_ok && hit_tsr) ? ~pwdata[1:0] : '0;
    assign tsr_d   = (tsr_q & ~tsr_clr) | {udf_set_i, ovf_set_i};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q <= '0;
            tcr_q <= '0;
            tsr_q <= '0;
        end else begin
            if (wr_ok && hit_tdr) begin
                tdr_q <= pwdata;
            end
            if (wr_ok && hit_tcr) begin
                tcr_q <= tcr_filter(pwdata);
            end
            tsr_q <= tsr_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_tdr) begin
            rdata = tdr_q;
        end else if (hit_tcr) begin
            rdata = tcr_q;
        end else if (hit_tsr) begin
            rdata = {6'b0, tsr_q};
        end else if (hit_tcnt) begin
            rdata = tcnt_i;
        end
    end

    // Read data is presented in the completion cycle and then held.
    assign rd_value = err ? '0 : rdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prdata_q <= '0;
        end else if (rd_stb) begin
            prdata_q <= rd_value;
        end
    end

    assign prdata = rd_stb ? rd_value : prdata_q;

    assign tdr_o  = tdr_q;
    assign load_o = tcr_q[TCR_LOAD];
    assign dn_o   = tcr_q[TCR_DN];
    assign en_o   = tcr_q[TCR_EN];
    assign cks_o  = tcr_q[TCR_CKS_HI:TCR_CKS_LO];

endmodule

// File: tb/tb_timer_apb_regif.sv
// Directed bench for timer_apb_regif: one instance with the default single
// wait state, one with three wait states, sharing the bus stimulus.
module tb_timer_apb_regif;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic [7:0] tcnt = 8'h3C;
    logic       ovf_set = 1'b0, udf_set = 1'b0;
    int         tgt = 0;

    logic       psel_a, psel_b;
    logic [7:0] prdata_a, prdata_b, tdr_a, tdr_b;
    logic       pready_a, pready_b, pslverr_a, pslverr_b;
    logic       load_a, load_b, dn_a, dn_b, en_a, en_b;
    logic [1:0] cks_a, cks_b;
    logic [7:0] prdata_m;
    logic       pready_m, pslverr_m;

    int errors = 0;
    int checks = 0;
    bit pulse_ovf_at_ready = 1'b0;
    bit pulse_udf_at_ready = 1'b0;

    logic [7:0] rd;
    logic       err;
    int         lat;

    always #5 pclk = ~pclk;

    assign psel_a    = psel && (tgt == 0);
    assign psel_b    = psel && (tgt == 1);
    assign prdata_m  = (tgt == 0) ? prdata_a  : prdata_b;
    assign pready_m  = (tgt == 0) ? pready_a  : pready_b;
    assign pslverr_m = (tgt == 0) ? pslverr_a : pslverr_b;

    timer_apb_regif dut_a (
        .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
        .pready(pready_a), .pslverr(pslverr_a), .tdr_o(tdr_a), .load_o(load_a),
        .dn_o(dn_a), .en_o(en_a), .cks_o(cks_a), .tcnt_i(tcnt),
        .ovf_set_i(ovf_set), .udf_set_i(udf_set)
    );

    timer_apb_regif #(.WAIT_STATES(3), .ADDR_W(8)) dut_b (
        .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
        .pready(pready_b), .pslverr(pslverr_b), .tdr_o(tdr_b), .load_o(load_b),
        .dn_o(dn_b), .en_o(en_b), .cks_o(cks_b), .tcnt_i(tcnt),
        .ovf_set_i(ovf_set), .udf_set_i(udf_set)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transfer on instance `tgt`; returns read data, error flag and wait count.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rdat, output logic e, output int wait_n);
        bit done = 1'b0;
        rdat   = 'x;
        e      = 1'bx;
        wait_n = -1;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (pready_m) begin
                if (pulse_ovf_at_ready) ovf_set = 1'b1;
                if (pulse_udf_at_ready) udf_set = 1'b1;
                #1;
                rdat   = prdata_m;
                e      = pslverr_m;
                wait_n = i;
                done   = 1'b1;
                break;
            end
        end
        check("pready_timeout", 32'(done), 32'd1);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; ovf_set = 1'b0; udf_set = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        xfer(1'b0, a, 8'h00, rd, err, lat);
        check(tag, 32'(rd), 32'(exp));
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge pclk);
        #1;
        check("rst_prdata", 32'(prdata_a), 32'h0);
        check("rst_pready", 32'(pready_a), 32'h0);
        check("rst_pslverr", 32'(pslverr_a), 32'h0);
        check("rst_ctrl", {tdr_a, load_a, dn_a, en_a, cks_a}, 32'h0);
        presetn = 1'b1;
        rd_chk("rst_tdr", 8'h00, 8'h00);
        rd_chk("rst_tcr", 8'h01, 8'h00);
        rd_chk("rst_tsr", 8'h02, 8'h00);

        // TDR / TCR writes drive the control outputs
        xfer(1'b1, 8'h00, 8'hFF, rd, err, lat);
        check("wr_tdr_err", 32'(err), 32'd0);
        check("wr_tdr_lat", 32'(lat), 32'd1);
        xfer(1'b1, 8'h01, 8'h80, rd, err, lat);
        #1;
        check("tdr_o", 32'(tdr_a), 32'hFF);
        check("tcr_outs_80", {load_a, dn_a, en_a, cks_a}, 32'b1_0_0_00);
        xfer(1'b1, 8'h01, 8'hFF, rd, err, lat);
        rd_chk("tcr_rsvd", 8'h01, 8'hB3);
        check("tcr_outs_ff", {load_a, dn_a, en_a, cks_a}, 32'b1_1_1_11);
        rd_chk("tcnt_rd", 8'h03, 8'h3C);

        // Sticky flags, write-0-to-clear
        @(posedge pclk); #1 ovf_set = 1'b1;
        @(posedge pclk); #1 ovf_set = 1'b0;
        rd_chk("tsr_ovf", 8'h02, 8'h01);
        xfer(1'b1, 8'h02, 8'h01, rd, err, lat);
        rd_chk("tsr_w1_keep", 8'h02, 8'h01);
        xfer(1'b1, 8'h02, 8'h00, rd, err, lat);
        rd_chk("tsr_w0_clr", 8'h02, 8'h00);

        // Set beats a same-cycle clear
        pulse_udf_at_ready = 1'b1;
        xfer(1'b1, 8'h02, 8'h00, rd, err, lat);
        pulse_udf_at_ready = 1'b0;
        rd_chk("tsr_set_wins", 8'h02, 8'h02);

        // Read coinciding with a set shows the old value, next read the new
        pulse_ovf_at_ready = 1'b1;
        xfer(1'b0, 8'h02, 8'h00, rd, err, lat);
        pulse_ovf_at_ready = 1'b0;
        check("tsr_rd_preset", 32'(rd), 32'h02);
        rd_chk("tsr_rd_after", 8'h02, 8'h03);

        // Error responses
        xfer(1'b0, 8'h05, 8'h00, rd, err, lat);
        check("unmapped_rd_err", 32'(err), 32'd1);
        check("unmapped_rd_data", 32'(rd), 32'h0);
        xfer(1'b1, 8'h03, 8'h55, rd, err, lat);
        check("tcnt_wr_err", 32'(err), 32'd1);
        xfer(1'b1, 8'h07, 8'h12, rd, err, lat);
        check("unmapped_wr_err", 32'(err), 32'd1);
        rd_chk("err_tdr_kept", 8'h00, 8'hFF);
        rd_chk("err_tcr_kept", 8'h01, 8'hB3);

        // Three wait states
        tgt = 1;
        xfer(1'b1, 8'h00, 8'h5A, rd, err, lat);
        check("ws3_lat", 32'(lat), 32'd3);
        #1;
        check("ws3_tdr", 32'(tdr_b), 32'h5A);

        // psel dropped before pready: no write
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hA5;
        @(posedge pclk); #1 penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        check("abort_tdr", 32'(tdr_b), 32'h5A);
        rd_chk("abort_rd", 8'h00, 8'h5A);

        // Reset in the middle of an access
        xfer(1'b1, 8'h01, 8'h91, rd, err, lat);
        #1;
        check("ws3_tcr_outs", {load_b, dn_b, en_b, cks_b}, 32'b1_0_1_01);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 presetn = 1'b0;
        #1;
        check("midrst_b", {prdata_b, pready_b, pslverr_b, tdr_b, load_b, dn_b, en_b, cks_b}, 32'h0);
        check("midrst_a", {tdr_a, load_a, dn_a, en_a, cks_a}, 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        presetn = 1'b1;
        repeat (4) @(posedge pclk);
        #1;
        check("postrst_tdr", 32'(tdr_b), 32'h0);
        rd_chk("postrst_rd", 8'h00, 8'h00);
        tgt = 0;
        rd_chk("postrst_tsr", 8'h02, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
